// File: rtl/main_memory_resp.sv
// -----------------------------------------------------------------------------
// main_memory_resp
//
// Single-outstanding-request line memory that sits behind a cache. A request
// is accepted in IDLE, writes land in the array on the accepting edge, and a
// response is presented exactly LATENCY cycles after the accept cycle. The
// response is held until the cache takes it with resp_ready.
//
// Parameters:
//   ADDR_WIDTH  byte address width (default 16 -> 64 kB)
//   LINE_WIDTH  line width in bits (default 128)
//   LATENCY     accept-to-response cycles, 1..15 (default 4)
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   req_valid   request present          req_ready   can accept (IDLE only)
//   req_we      1 = write-back, 0 = read req_addr    byte address of the line
//   req_wdata   write-back line data
//   resp_valid  response present (RESP)  resp_ready  cache takes response
//   resp_rdata  refill data (zero for writes and flagged requests)
//   resp_err    misaligned-request flag
//
// Build option:
//   MAIN_MEM_ALIGN_CHECK_EN  when defined, a request with a non-zero line
//   offset is flagged: no array write, zero data, resp_err=1. When undefined
//   the offset bits are ignored and resp_err is always 0.
//
// State table:
//   IDLE | ready for a request, req_ready=1
//   WAIT | counting down the remaining latency
//   RESP | response held on the outputs until resp_ready
// -----------------------------------------------------------------------------
module main_memory_resp #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LINE_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rerr_q, rerr_d;

  logic [LINE_WIDTH-1:0] mem_q [DEPTH];

  logic             accept;
  logic             misalign;
  logic             mem_wr;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_we;
  logic             rd_err;

  assign req_idx = req_addr[ADDR_WIDTH-1:OFF_W];

`ifdef MAIN_MEM_ALIGN_CHECK_EN
  assign misalign = |req_addr[OFF_W-1:0];
`else
  logic unused_offset;
  assign misalign      = 1'b0;
  assign unused_offset = ^req_addr[OFF_W-1:0];
`endif

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready && rst_n;
  // The write lands on the accepting edge, so wdata never needs holding.
  assign mem_wr     = accept && req_we && !misalign;

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

  // With LATENCY=1 the response is captured on the accepting edge itself, so
  // the response source comes straight from the request in IDLE.
  assign rd_idx = (state_q == IDLE) ? req_idx  : idx_q;
  assign rd_we  = (state_q == IDLE) ? req_we   : we_q;
  assign rd_err = (state_q == IDLE) ? misalign : err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d  = req_we;
          err_d = misalign;
          idx_d = req_idx;
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the response once on entry to RESP so it stays stable while
    // the cache stalls.
    if ((state_d == RESP) && (state_q != RESP)) begin
      rdata_d = (rd_we || rd_err) ? '0 : mem_q[rd_idx];
      rerr_d  = rd_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[req_idx] <= req_wdata;
    end
  end

endmodule

// File: tb/tb_main_memory_resp.sv
module tb_main_memory_resp;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] D2 = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D3 = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;
  localparam logic [127:0] D4 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] ZERO = 128'h0;

`ifdef MAIN_MEM_ALIGN_CHECK_EN
  localparam logic         MIS_ERR  = 1'b1;
  localparam logic [127:0] LINE100  = D3;
`else
  localparam logic         MIS_ERR  = 1'b0;
  localparam logic [127:0] LINE100  = D4;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_we;
  logic [15:0]  req_addr;
  logic [127:0] req_wdata;
  logic         rv4, rv1, rr4, rr1, sv4, sv1, sr4, sr1, er4, er1;
  logic [127:0] rd4, rd1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  main_memory_resp #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rr4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(sv4), .resp_ready(sr4),
    .resp_rdata(rd4), .resp_err(er4)
  );

  main_memory_resp #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(sv1), .resp_ready(sr1),
    .resp_rdata(rd1), .resp_err(er1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return (s != 0) ? rr1 : rr4;
  endfunction

  function automatic logic rspv(input int s);
    return (s != 0) ? sv1 : sv4;
  endfunction

  function automatic logic [127:0] rdat(input int s);
    return (s != 0) ? rd1 : rd4;
  endfunction

  function automatic logic rerr(input int s);
    return (s != 0) ? er1 : er4;
  endfunction

  task automatic set_valid(input int s, input logic v);
    if (s != 0) rv1 = v; else rv4 = v;
  endtask

  task automatic set_ready(input int s, input logic v);
    if (s != 0) sr1 = v; else sr4 = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/response; after the accept the request bus is left holding
  // junk with req_we=1 and req_valid=0, which must not reach the array.
  task automatic xact(input int s, input logic we, input logic [15:0] addr,
                      input logic [127:0] wd, input int exp_lat,
                      input logic [127:0] exp_rd, input logic exp_err,
                      input int hold, input string tag);
    logic acc;
    int lat;
    logic [127:0] snap;
    req_we = we; req_addr = addr; req_wdata = wd;
    set_valid(s, 1'b1);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = rdy(s);
      tick();
    end
    set_valid(s, 1'b0);
    req_we = 1'b1; req_wdata = ~wd;
    chk({tag, "_accept"}, 128'(acc), 128'(1));
    lat = 1;
    while (!rspv(s) && lat < 30) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_rdata"}, rdat(s), exp_rd);
    chk({tag, "_err"}, 128'(rerr(s)), 128'(exp_err));
    snap = rdat(s);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 128'(rspv(s)), 128'(1));
      chk({tag, "_hold_rdata"}, rdat(s), snap);
      chk({tag, "_hold_ready"}, 128'(rdy(s)), 128'(0));
    end
    set_ready(s, 1'b1);
    tick();
    set_ready(s, 1'b0);
    chk({tag, "_done_valid"}, 128'(rspv(s)), 128'(0));
    chk({tag, "_done_ready"}, 128'(rdy(s)), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rv4 = 1'b0; rv1 = 1'b0; sr4 = 1'b0; sr1 = 1'b0;
    tick();
    tick();
    chk("rst_ready4", 128'(rr4), 128'(1));
    chk("rst_valid4", 128'(sv4), 128'(0));
    chk("rst_rdata4", rd4, ZERO);
    chk("rst_err4",   128'(er4), 128'(0));
    chk("rst_ready1", 128'(rr1), 128'(1));
    chk("rst_valid1", 128'(sv1), 128'(0));
    rst_n = 1'b1;
    tick();

    // Write then immediate read of the same line.
    xact(0, 1'b1, 16'h0040, D1, 4, ZERO, 1'b0, 0, "wr40");
    xact(0, 1'b0, 16'h0040, 128'h0, 4, D1, 1'b0, 0, "rd40");

    // Response stalled 6 cycles.
    xact(0, 1'b1, 16'h0050, D2, 4, ZERO, 1'b0, 0, "wr50");
    xact(0, 1'b0, 16'h0040, 128'h0, 4, D1, 1'b0, 6, "rd40_stall");
    xact(0, 1'b0, 16'h0050, 128'h0, 4, D2, 1'b0, 0, "rd50");

    // LATENCY=1 instance at the top line.
    xact(1, 1'b1, 16'hFFF0, ONES, 1, ZERO, 1'b0, 0, "l1_wrfff0");
    xact(1, 1'b0, 16'hFFF0, 128'h0, 1, ONES, 1'b0, 0, "l1_rdfff0");

    // Reset during WAIT of a write to 0x0100.
    req_we = 1'b1; req_addr = 16'h0100; req_wdata = D3; rv4 = 1'b1;
    chk("rstw_ready_pre", 128'(rr4), 128'(1));
    tick();
    rv4 = 1'b0;
    chk("rstw_in_wait", 128'(rr4), 128'(0));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstw_ready", 128'(rr4), 128'(1));
    chk("rstw_valid", 128'(sv4), 128'(0));
    chk("rstw_rdata", rd4, ZERO);
    chk("rstw_err",   128'(er4), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstw_no_resp", 128'(sv4), 128'(0));
    end
    xact(0, 1'b0, 16'h0100, 128'h0, 4, D3, 1'b0, 0, "rd100_after_rst");

    // Misaligned write to 0x0104.
    xact(0, 1'b1, 16'h0104, D4, 4, ZERO, MIS_ERR, 0, "wr104");
    xact(0, 1'b0, 16'h0100, 128'h0, 4, LINE100, 1'b0, 0, "rd100_after_104");

    // req_valid held through WAIT/RESP: the second request waits for IDLE.
    req_we = 1'b0; req_addr = 16'h0040; req_wdata = '0; rv4 = 1'b1;
    chk("bb_ready_a", 128'(rr4), 128'(1));
    tick();
    req_addr = 16'h0050;
    for (int i = 1; i < 4; i++) begin
      chk("bb_wait_ready", 128'(rr4), 128'(0));
      chk("bb_wait_valid", 128'(sv4), 128'(0));
      tick();
    end
    chk("bb_resp_a_valid", 128'(sv4), 128'(1));
    chk("bb_resp_a_rdata", rd4, D1);
    tick();
    tick();
    chk("bb_resp_hold_ready", 128'(rr4), 128'(0));
    chk("bb_resp_hold_rdata", rd4, D1);
    sr4 = 1'b1;
    tick();
    sr4 = 1'b0;
    chk("bb_idle_ready", 128'(rr4), 128'(1));
    chk("bb_idle_valid", 128'(sv4), 128'(0));
    tick();
    rv4 = 1'b0;
    chk("bb_b_accepted", 128'(rr4), 128'(0));
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) begin
        chk("bb_b_wait_valid", 128'(sv4), 128'(0));
        tick();
      end else begin
        chk("bb_resp_b_valid", 128'(sv4), 128'(1));
        chk("bb_resp_b_rdata", rd4, D2);
      end
    end
    sr4 = 1'b1;
    tick();
    sr4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("bb_no_extra_resp", 128'(sv4), 128'(0));
      chk("bb_idle_after", 128'(rr4), 128'(1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
